uncore_access_seq: RTL

Single-outstanding access sequencer between the uncore bus request port and the memory-mapped peripherals.
- Captures one request and presents the latched address and size to the region address decoders.
- Samples their one-hot region select a cycle later and drives the selected peripheral until it completes or times out.
- Returns read data or an access-fault response to the requester.
- Sits in the uncore between the bus-side adapter and the peripheral select/read-data mux.

---
 rtl/uncore_access_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uncore_access_seq.sv
// Single-outstanding access sequencer between the uncore request port and the
// memory-mapped peripherals. It accepts one request, presents the latched
// address/size to the region decoders, samples their one-hot result a cycle
// later, drives the selected peripheral until it completes or times out, and
// returns read data or an access fault.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ReqValid/ReqReady               request handshake (ready only in IDLE)
//   ReqAdr/ReqWrite/ReqSize/ReqWData request payload
//   DecAdr/DecSize                  latched address/size to region decoders
//   SelRegions                      decoder result, bit 0 = no region hit
//   PeriphSel/PeriphWrite/PeriphWData peripheral drive during ACCESS
//   PeriphReady/PeriphRData         muxed peripheral completion/read data
//   RspValid/RspReady               response handshake
//   RspRData/RspErr                 response payload (data 0 on write/fault)
//   FaultCount                      saturating count of faulted requests
module uncore_access_seq #(
  parameter int unsigned PA_BITS        = 34,
  parameter int unsigned XLEN           = 64,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned NREG           = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [PA_BITS-1:0]  ReqAdr,
  input  logic                ReqWrite,
  input  logic [1:0]          ReqSize,
  input  logic [XLEN-1:0]     ReqWData,
  output logic [PA_BITS-1:0]  DecAdr,
  output logic [1:0]          DecSize,
  input  logic [NREG-1:0]     SelRegions,
  output logic [NREG-2:0]     PeriphSel,
  output logic                PeriphWrite,
  output logic [XLEN-1:0]     PeriphWData,
  input  logic                PeriphReady,
  input  logic [XLEN-1:0]     PeriphRData,
  output logic                RspValid,
  input  logic                RspReady,
  output logic [XLEN-1:0]     RspRData,
  output logic                RspErr,
  output logic [7:0]          FaultCount
);

  localparam int unsigned SEL_W = NREG - 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DECODE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic [PA_BITS-1:0] adr_q;
  logic [1:0]         size_q;
  logic               write_q;
  logic [XLEN-1:0]    wdata_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]    rdata_q;
  logic               err_q;
  logic [7:0]         fault_q;

  logic [SEL_W-1:0]   hits_c;
  logic               multi_hit_c;
  logic               accept_c, dec_fault_c, dec_ok_c;
  logic               acc_done_c, acc_tmo_c, rsp_take_c;

  // More than one real region selected: x & (x-1) clears the lowest set bit.
  assign hits_c      = SelRegions[NREG-1:1];
  assign multi_hit_c = |(hits_c & (hits_c - SEL_W'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-state event decode
  always_comb begin
    state_d     = state_q;
    accept_c    = 1'b0;
    dec_fault_c = 1'b0;
    dec_ok_c    = 1'b0;
    acc_done_c  = 1'b0;
    acc_tmo_c   = 1'b0;
    rsp_take_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          accept_c = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (SelRegions[0] || multi_hit_c) begin
          dec_fault_c = 1'b1;
          state_d     = RESP;
        end else begin
          dec_ok_c = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // Completion in the last counted cycle takes priority over timeout.
        if (PeriphReady) begin
          acc_done_c = 1'b1;
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          acc_tmo_c = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (RspReady) begin
          rsp_take_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, select/timeout tracking, response and fault registers
  always_ff @(posedge clk) begin
    if (reset) begin
      adr_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      fault_q <= '0;
    end else begin
      if (accept_c) begin
        adr_q   <= ReqAdr;
        size_q  <= ReqSize;
        write_q <= ReqWrite;
        wdata_q <= ReqWData;
      end
      if (dec_ok_c) begin
        sel_q <= hits_c;
        cnt_q <= '0;
      end
      if (state_q == ACCESS && !acc_done_c && !acc_tmo_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (dec_fault_c || acc_tmo_c) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        if (fault_q != 8'hFF) fault_q <= fault_q + 8'd1;
      end
      if (acc_done_c) begin
        rdata_q <= write_q ? '0 : PeriphRData;
        err_q   <= 1'b0;
      end
      if (rsp_take_c) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Outputs are registers or a function of state and registers only
  assign ReqReady    = (state_q == IDLE);
  assign DecAdr      = adr_q;
  assign DecSize     = size_q;
  assign PeriphSel   = (state_q == ACCESS) ? sel_q : '0;
  assign PeriphWrite = (state_q == ACCESS) && write_q;
  assign PeriphWData = wdata_q;
  assign RspValid    = (state_q == RESP);
  assign RspRData    = rdata_q;
  assign RspErr      = err_q;
  assign FaultCount  = fault_q;

endmodule
